hazard_unit_seq: RTL and testbench

HAZARD_UNIT_SEQ -- requirements
Module: hazard_unit_seq

---
 rtl/hazard_unit_seq.sv | 110 +++++++++++
 tb/tb_hazard_unit_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_seq.sv
// Purpose: pipeline hazard unit with a private E/M/W shadow, forwarding selects, load-use stall and event counters.
// Latency: stall/flush/forward outputs are combinational (zero cycle); shadow and counters update on the clock edge.
// Backpressure: none accepted; StallF/StallD hold fetch/decode and FlushD/FlushE clear decode/execute.
module hazard_unit_seq #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,
    input  logic             RegWriteD,
    input  logic [1:0]       ResultSrcD,
    input  logic             PCSrcE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       regWrite;
        logic       isLoad;
    } shadow_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_WB   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    shadow_t shadowE, shadowM, shadowW;
    shadow_t stageD;
    logic    lwStall;

    // Only rd/regWrite of M and W and only E's rs/rd/load matter for the decisions;
    // the remaining shadow fields are kept so the shadow mirrors the real pipeline.
    logic unusedShadowBits;
    assign unusedShadowBits = ^{shadowM.rs1, shadowM.rs2, shadowM.isLoad,
                                shadowW.rs1, shadowW.rs2, shadowW.isLoad,
                                shadowE.regWrite};

    // Pack the decode-stage instruction into the shadow format.
    always_comb begin
        stageD          = '0;
        stageD.rs1      = Rs1D;
        stageD.rs2      = Rs2D;
        stageD.rd       = RdD;
        stageD.regWrite = RegWriteD;
        stageD.isLoad   = (ResultSrcD == 2'b01);
    end

    // Load-use detection and the stall/flush controls; reset forces both flushes high.
    always_comb begin
        lwStall = shadowE.isLoad && (shadowE.rd != 5'd0) &&
                  ((Rs1D == shadowE.rd) || (Rs2D == shadowE.rd));
        StallF  = lwStall && !reset;
        StallD  = lwStall && !reset;
        FlushD  = PCSrcE || reset;
        FlushE  = lwStall || PCSrcE || reset;
    end

    // Forward selects: M beats W, and x0 is never forwarded.
    always_comb begin
        ForwardAE = FWD_NONE;
        ForwardBE = FWD_NONE;
        if (shadowE.rs1 != 5'd0 && shadowM.regWrite && shadowE.rs1 == shadowM.rd)
            ForwardAE = FWD_MEM;
        else if (shadowE.rs1 != 5'd0 && shadowW.regWrite && shadowE.rs1 == shadowW.rd)
            ForwardAE = FWD_WB;
        if (shadowE.rs2 != 5'd0 && shadowM.regWrite && shadowE.rs2 == shadowM.rd)
            ForwardBE = FWD_MEM;
        else if (shadowE.rs2 != 5'd0 && shadowW.regWrite && shadowE.rs2 == shadowW.rd)
            ForwardBE = FWD_WB;
    end

    // Advance the shadow pipeline; a flushed E slot becomes an all-zero bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadowE <= '0;
            shadowM <= '0;
            shadowW <= '0;
        end else begin
            shadowE <= FlushE ? '0 : stageD;
            shadowM <= shadowE;
            shadowW <= shadowM;
        end
    end

    // Saturating event counters for load-use stalls and control flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            StallCount <= '0;
            FlushCount <= '0;
        end else begin
            if (lwStall && StallCount != '1)
                StallCount <= StallCount + CNT_ONE;
            if (PCSrcE && FlushCount != '1)
                FlushCount <= FlushCount + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_hazard_unit_seq.sv
// Purpose: scoreboard bench for hazard_unit_seq with 4-bit counters.
// Latency: expectations are pushed when a decode instruction is driven and popped 2 ns after that negedge.
// Backpressure: not applicable; one instruction is presented per cycle.
module tb_hazard_unit_seq;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = 15;

    logic             clk;
    logic             reset;
    logic [4:0]       Rs1D, Rs2D, RdD;
    logic             RegWriteD;
    logic [1:0]       ResultSrcD;
    logic             PCSrcE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, FlushD, FlushE;
    logic [CNT_W-1:0] StallCount, FlushCount;

    typedef struct {
        int         id;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       st;
        logic       fd;
        logic       fe;
        int         sc;
        int         fc;
    } exp_t;

    exp_t sbQ[$];
    int   nChecks = 0;
    int   nPass   = 0;
    int   stepNo  = 0;
    int   expS    = 0;
    int   expF    = 0;

    hazard_unit_seq #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdD        (RdD),
        .RegWriteD  (RegWriteD),
        .ResultSrcD (ResultSrcD),
        .PCSrcE     (PCSrcE),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .StallCount (StallCount),
        .FlushCount (FlushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            nPass++;
    endtask

    task automatic pushExp(input logic [1:0] efa, input logic [1:0] efb,
                           input logic est, input logic efd, input logic efe);
        exp_t e;
        stepNo++;
        e.id = stepNo;
        e.fa = efa;
        e.fb = efb;
        e.st = est;
        e.fd = efd;
        e.fe = efe;
        e.sc = expS;
        e.fc = expF;
        sbQ.push_back(e);
    endtask

    // One decode-stage instruction per cycle; expected outputs for this cycle go to the scoreboard.
    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic rw, input logic ld, input logic pc,
                         input logic [1:0] efa, input logic [1:0] efb, input logic est);
        @(negedge clk);
        Rs1D       = rs1;
        Rs2D       = rs2;
        RdD        = rd;
        RegWriteD  = rw;
        ResultSrcD = ld ? 2'b01 : 2'b00;
        PCSrcE     = pc;
        pushExp(efa, efb, est, pc, est | pc);
        if (est) expS = (expS == CNT_MAX) ? CNT_MAX : expS + 1;
        if (pc)  expF = (expF == CNT_MAX) ? CNT_MAX : expF + 1;
        @(posedge clk);
    endtask

    // A cycle with reset held: controls must sit at their reset values whatever D/PCSrcE say.
    task automatic resetStep(input logic pc);
        @(negedge clk);
        reset      = 1'b1;
        Rs1D       = 5'd9;
        Rs2D       = 5'd9;
        RdD        = 5'd9;
        RegWriteD  = 1'b1;
        ResultSrcD = 2'b01;
        PCSrcE     = pc;
        pushExp(2'b00, 2'b00, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
    endtask

    task automatic setNop();
        Rs1D = 5'd0; Rs2D = 5'd0; RdD = 5'd0;
        RegWriteD = 1'b0; ResultSrcD = 2'b00; PCSrcE = 1'b0;
    endtask

    // Scoreboard consumer: compare every pending expectation against the live outputs.
    always @(negedge clk) begin
        exp_t e;
        #2;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            chk($sformatf("ForwardAE@%0d", e.id), 32'(ForwardAE), 32'(e.fa));
            chk($sformatf("ForwardBE@%0d", e.id), 32'(ForwardBE), 32'(e.fb));
            chk($sformatf("StallF@%0d", e.id), 32'(StallF), 32'(e.st));
            chk($sformatf("StallD@%0d", e.id), 32'(StallD), 32'(e.st));
            chk($sformatf("FlushD@%0d", e.id), 32'(FlushD), 32'(e.fd));
            chk($sformatf("FlushE@%0d", e.id), 32'(FlushE), 32'(e.fe));
            chk($sformatf("StallCount@%0d", e.id), 32'(StallCount), 32'(e.sc));
            chk($sformatf("FlushCount@%0d", e.id), 32'(FlushCount), 32'(e.fc));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end (time %0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        setNop();
        resetStep(1'b0);
        resetStep(1'b1);
        @(negedge clk);
        setNop();
        reset = 1'b0;

        // back-to-back ALU: add x5 then a consumer of x5
        drive(5'd1, 5'd2, 5'd5,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd5, 5'd6, 5'd8,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0);
        // two-apart dependency on x7 through rs2
        drive(5'd1, 5'd2, 5'd7,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd3, 5'd4, 5'd10, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd7, 5'd11, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0);
        // x3 pending in both M and W: M wins
        drive(5'd0, 5'd0, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd0, 5'd3,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd3, 5'd3, 5'd12, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0);
        drive(5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        // x0 writer in M with rs1E = 0, then lw x0 followed by rs1 = 0
        drive(5'd0, 5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd1, 5'd2, 5'd0,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd0, 5'd14, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        // load-use on x9: one stall, bubble, then forward from W
        drive(5'd0, 5'd0, 5'd9,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd9, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
        drive(5'd9, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0);
        // stall and taken branch in the same cycle, then a branch alone
        drive(5'd0, 5'd0, 5'd9,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd9, 5'd16, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1);
        drive(5'd0, 5'd0, 5'd0,  1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0);
        drive(5'd0, 5'd0, 5'd9,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);

        // reset asserted asynchronously while a load-use stall is active
        @(negedge clk);
        Rs1D = 5'd9; Rs2D = 5'd9; RdD = 5'd17; RegWriteD = 1'b1; ResultSrcD = 2'b00; PCSrcE = 1'b0;
        pushExp(2'b00, 2'b00, 1'b1, 1'b0, 1'b1);
        #4;
        reset = 1'b1;
        expS = 0;
        expF = 0;
        #1;
        chk("rstMid.StallF", 32'(StallF), 32'd0);
        chk("rstMid.StallD", 32'(StallD), 32'd0);
        chk("rstMid.FlushD", 32'(FlushD), 32'd1);
        chk("rstMid.FlushE", 32'(FlushE), 32'd1);
        chk("rstMid.ForwardAE", 32'(ForwardAE), 32'd0);
        chk("rstMid.StallCount", 32'(StallCount), 32'd0);
        chk("rstMid.FlushCount", 32'(FlushCount), 32'd0);
        @(posedge clk);
        @(negedge clk);
        setNop();
        reset = 1'b0;

        // 20 load-use stalls into a 4-bit counter: must stop at 4'hF
        for (int i = 0; i < 20; i++) begin
            drive(5'd0, 5'd0, 5'd9,  1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
            drive(5'd9, 5'd0, 5'd15, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);

        @(negedge clk);
        #3;
        chk("satStallCount", 32'(StallCount), 32'hF);
        chk("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
